div_ctrl: RTL and testbench

Multi-cycle integer divide sequencer for the EX stage. Accepts a divide request (DIV/DIVU) from EX, captures the operands, runs a 32-step restoring division one bit per cycle, applies sign correction, and presents the 64-bit {remainder, quotient} result with a ready flag until EX releases the request. EX holds its stall request high while `ready_o` is low and writes `result_o[63:32]` to HI and `result_o[31:0]` to LO.

---
 rtl/div_ctrl_pkg.sv | 26 ++
 rtl/div_ctrl_step.sv | 25 ++
 rtl/div_ctrl.sv | 131 +++++++++++++
 tb/tb_div_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the EX-stage divide sequencer.
// Zero-divisor shortcut is selected by the DIV_ZERO_FAST_EN macro.
package div_ctrl_pkg;

    localparam int REG_BUS    = 32;
    localparam int DOUBLE_BUS = 64;

    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    function automatic logic [REG_BUS-1:0] neg_if(input logic en, input logic [REG_BUS-1:0] v);
        return en ? (ZERO_WORD - v) : v;
    endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
    import div_ctrl_pkg::*;
(
    input  logic [REG_BUS-1:0] r_i,
    input  logic [REG_BUS-1:0] q_i,
    input  logic [REG_BUS-1:0] d_i,
    output logic [REG_BUS-1:0] r_o,
    output logic [REG_BUS-1:0] q_o
);

    logic [REG_BUS:0] t;
    logic [REG_BUS:0] diff;
    logic             ge;

    // Full 33-bit trial keeps divisors above 2^31 correct.
    assign t    = {r_i, q_i[REG_BUS-1]};
    assign diff = t - {1'b0, d_i};
    assign ge   = (t >= {1'b0, d_i});

    assign r_o = ge ? diff[REG_BUS-1:0] : t[REG_BUS-1:0];
    assign q_o = {q_i[REG_BUS-2:0], ge};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle 32-step restoring divide sequencer (DIV/DIVU) for EX.
// Define DIV_ZERO_FAST_EN to short-circuit a zero divisor to a 0 result.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_i,
    input  logic [REG_BUS-1:0]    opdata1_i,
    input  logic [REG_BUS-1:0]    opdata2_i,
    output logic [DOUBLE_BUS-1:0] result_o,
    output logic                  ready_o
);

    div_state_e            state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [REG_BUS-1:0]    r_q, r_d, q_q, q_d, d_q, d_d;
    logic                  sq_q, sq_d, sr_q, sr_d;
    logic [DOUBLE_BUS-1:0] result_q, result_d;
    logic                  ready_q, ready_d;

    logic [REG_BUS-1:0]    r_nxt, q_nxt;
    logic [REG_BUS-1:0]    op1_mag, op2_mag;
    logic                  zero_fast;

    div_step u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (r_nxt),
        .q_o (q_nxt)
    );

    assign op1_mag = neg_if(signed_i & opdata1_i[REG_BUS-1], opdata1_i);
    assign op2_mag = neg_if(signed_i & opdata2_i[REG_BUS-1], opdata2_i);

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (opdata2_i == ZERO_WORD);
`else
    assign zero_fast = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            sq_q     <= 1'b0;
            sr_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            q_q      <= q_d;
            d_q      <= d_d;
            sq_q     <= sq_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        sq_d     = sq_q;
        sr_d     = sr_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                // Flush wins over a new request.
                if (start_i == DIV_START && !annul_i) begin
                    r_d     = ZERO_WORD;
                    q_d     = op1_mag;
                    d_d     = op2_mag;
                    cnt_d   = '0;
                    sq_d    = signed_i & (opdata1_i[REG_BUS-1] ^ opdata2_i[REG_BUS-1]);
                    sr_d    = signed_i & opdata1_i[REG_BUS-1];
                    state_d = zero_fast ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_d = DIV_FREE;
                end else begin
                    r_d   = r_nxt;
                    q_d   = q_nxt;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = DIV_END;
                        result_d = {neg_if(sr_q, r_nxt), neg_if(sq_q, q_nxt)};
                        ready_d  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_END: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: arithmetic reference model plus per-cycle
// output comparison and a few hand-computed literal results.
module tb_div_ctrl;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start_i, annul_i, signed_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;

    logic        chk_en = 1'b0;
    logic        exp_ready = 1'b0;
    logic [63:0] exp_result = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain magnitude divide with sign fix-up.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb, q, r;
        ma = (s && a[31]) ? 32'(-a) : a;
        mb = (s && b[31]) ? 32'(-b) : b;
        if (mb == 0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (s && (a[31] ^ b[31])) q = -q;
        if (s && a[31]) r = -r;
        if (mb == 0 && FAST) return 64'd0;
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_o", {63'd0, ready_o}, {63'd0, exp_ready});
            check("result_o", result_o, exp_result);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int hold, input bit has_lit, input logic [63:0] lit);
        int lat;
        logic [63:0] got;
        lat = (b == 0 && FAST) ? 1 : 32;
        opdata1_i = a; opdata2_i = b; signed_i = s; start_i = 1'b1;
        exp_ready = 1'b0; exp_result = '0;
        tick();
        // Operands must be ignored after capture.
        opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0000_0003; signed_i = ~s;
        for (int i = 1; i <= lat; i++) begin
            tick();
            if (i == lat) begin
                exp_ready = 1'b1;
                exp_result = model(a, b, s);
            end
        end
        #2;
        got = result_o;
        for (int h = 0; h < hold; h++) tick();
        start_i = 1'b0;
        tick();
        exp_ready = 1'b0; exp_result = '0;
        tick();
        if (has_lit) check("literal", got, lit);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        tick(); tick();
        check("reset ready", {63'd0, ready_o}, 64'd0);
        check("reset result", result_o, 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        check("model 7/2", model(32'd7, 32'd2, 1'b0), 64'h00000001_00000003);
        check("model -7/2", model(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
        check("model 7/-2", model(32'd7, 32'hFFFF_FFFE, 1'b1), 64'h00000001_FFFFFFFD);

        run_div(32'd7, 32'd2, 1'b0, 0, 1'b1, 64'h00000001_00000003);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b1, 64'h00000001_FFFFFFFD);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, 64'h00000000_80000000);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b1, 64'h00000000_FFFFFFFF);
        run_div(32'd5, 32'd0, 1'b0, 0, 1'b1, FAST ? 64'd0 : 64'h00000005_FFFFFFFF);
        run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 0, 1'b0, 64'd0);
        run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, 1'b1, 64'h7FFFFFFE_00000001);
        run_div(32'd1000, 32'd7, 1'b0, 5, 1'b1, 64'h00000006_0000008E);

        // Flush pulse at step 10; no result may appear.
        opdata1_i = 32'd100; opdata2_i = 32'd9; signed_i = 1'b0; start_i = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 34; i++) tick();
        run_div(32'd100, 32'd9, 1'b0, 0, 1'b1, 64'h00000001_0000000B);

        // Request withdrawn mid-operation.
        opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) tick();
        start_i = 1'b0;
        for (int i = 0; i < 34; i++) tick();

        // Synchronous reset mid-operation.
        opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 34; i++) tick();

        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 2, 1'b1, 64'hFFFFFFFE_0000000E);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
